wishbone_mst_std_cmd: RTL

Wishbone classic single-cycle bus master that converts a valid/ready command stream into read/write bus cycles toward the standard memory-mapped Wishbone slave. It returns one response per accepted command, with read data and a completion status. It retries on RTY and aborts on ERR or timeout. It sits directly upstream of the slave and drives its CYC/STB/WE/ADR/DAT/SEL/TAGN inputs.

---
 rtl/wishbone_mst_std_cmd.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/wishbone_mst_std_cmd.sv
// Wishbone classic master: turns a valid/ready command stream into single bus
// cycles with RTY re-issue, ERR/timeout abort and one response per command.
module wishbone_mst_std_cmd #(
    parameter int p_DATA_WIDTH = 32,
    parameter int p_ADDR_WIDTH = 5,
    parameter int p_TIMEOUT    = 15,
    parameter int p_MAX_RETRY  = 3
) (
    input  logic                    i_CLK_I,
    input  logic                    i_RST_I,
    input  logic                    i_CMD_VALID,
    output logic                    o_CMD_READY,
    input  logic                    i_CMD_WE,
    input  logic [p_ADDR_WIDTH-1:0] i_CMD_ADR,
    input  logic [p_DATA_WIDTH-1:0] i_CMD_DAT,
    input  logic [p_DATA_WIDTH-1:0] i_CMD_SEL,
    input  logic [p_DATA_WIDTH-1:0] i_CMD_TAG,
    output logic                    o_RSP_VALID,
    output logic [p_DATA_WIDTH-1:0] o_RSP_DAT,
    output logic [1:0]              o_RSP_STS,
    output logic [p_DATA_WIDTH-1:0] o_RSP_TAG,
    output logic                    o_CYC_O,
    output logic                    o_STB_O,
    output logic                    o_WE_O,
    output logic [p_ADDR_WIDTH-1:0] o_ADR_O,
    output logic [p_DATA_WIDTH-1:0] o_DAT_O,
    output logic [p_DATA_WIDTH-1:0] o_SEL_O,
    output logic [p_DATA_WIDTH-1:0] o_TAGN_O,
    input  logic [p_DATA_WIDTH-1:0] i_DAT_I,
    input  logic [p_DATA_WIDTH-1:0] i_TAGN_I,
    input  logic                    i_ACK_I,
    input  logic                    i_ERR_I,
    input  logic                    i_RTY_I
);

    localparam int TW = $clog2(p_TIMEOUT + 1);
    localparam int RW = (p_MAX_RETRY > 0) ? $clog2(p_MAX_RETRY + 1) : 1;

    localparam logic [1:0] STS_OK  = 2'b00;
    localparam logic [1:0] STS_ERR = 2'b01;
    localparam logic [1:0] STS_TMO = 2'b10;
    localparam logic [1:0] STS_RTY = 2'b11;

    typedef enum logic [1:0] {IDLE, BUS, GAP} state_t;

    state_t            state, state_nxt;
    logic [TW-1:0]     tmo_cnt;
    logic [RW-1:0]     rty_cnt;
    logic              retry_pend;

    logic              accept, in_bus;
    logic              t_err, t_rty, t_ack, t_tmo;
    logic              retry, give_up, respond;

    logic [1:0]              sts_d;
    logic [p_DATA_WIDTH-1:0] dat_d, tag_d;
    logic                    ready_d, cyc_d;

    // Termination decode, priority ERR > RTY > ACK > timeout.
    assign accept  = (state == IDLE) && o_CMD_READY && i_CMD_VALID;
    assign in_bus  = (state == BUS);
    assign t_err   = in_bus && i_ERR_I;
    assign t_rty   = in_bus && !i_ERR_I && i_RTY_I;
    assign t_ack   = in_bus && !i_ERR_I && !i_RTY_I && i_ACK_I;
    assign t_tmo   = in_bus && !i_ERR_I && !i_RTY_I && !i_ACK_I &&
                     (tmo_cnt == TW'(p_TIMEOUT - 1));
    assign retry   = t_rty && (rty_cnt < RW'(p_MAX_RETRY));
    assign give_up = t_rty && !retry;
    assign respond = t_err || t_ack || give_up || t_tmo;

    always_ff @(posedge i_CLK_I or negedge i_RST_I) begin
        if (!i_RST_I) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUS;
            BUS:     if (respond || retry) state_nxt = GAP;
            GAP:     state_nxt = retry_pend ? BUS : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_d = (state_nxt == IDLE);
        cyc_d   = (state_nxt == BUS);
        sts_d   = STS_OK;
        if (t_err)        sts_d = STS_ERR;
        else if (give_up) sts_d = STS_RTY;
        else if (t_tmo)   sts_d = STS_TMO;
        dat_d   = (t_ack && !o_WE_O) ? i_DAT_I : '0;
        tag_d   = t_ack ? i_TAGN_I : '0;
    end

    always_ff @(posedge i_CLK_I or negedge i_RST_I) begin
        if (!i_RST_I) begin
            o_CMD_READY <= 1'b0;
            o_CYC_O     <= 1'b0;
            o_STB_O     <= 1'b0;
            o_WE_O      <= 1'b0;
            o_ADR_O     <= '0;
            o_DAT_O     <= '0;
            o_SEL_O     <= '0;
            o_TAGN_O    <= '0;
            o_RSP_VALID <= 1'b0;
            o_RSP_DAT   <= '0;
            o_RSP_STS   <= '0;
            o_RSP_TAG   <= '0;
            tmo_cnt     <= '0;
            rty_cnt     <= '0;
            retry_pend  <= 1'b0;
        end else begin
            o_CMD_READY <= ready_d;
            o_CYC_O     <= cyc_d;
            o_STB_O     <= cyc_d;
            o_RSP_VALID <= respond;
            if (respond) begin
                o_RSP_STS <= sts_d;
                o_RSP_DAT <= dat_d;
                o_RSP_TAG <= tag_d;
            end
            // Bus fields are captured once per command and held through retries.
            if (accept) begin
                o_WE_O   <= i_CMD_WE;
                o_ADR_O  <= i_CMD_ADR;
                o_DAT_O  <= i_CMD_DAT;
                o_SEL_O  <= i_CMD_SEL;
                o_TAGN_O <= i_CMD_TAG;
                rty_cnt  <= '0;
            end else if (retry) begin
                rty_cnt  <= rty_cnt + RW'(1);
            end
            if (retry)
                retry_pend <= 1'b1;
            else if (state == GAP || accept)
                retry_pend <= 1'b0;
            // Cleared on every entry to BUS, counts only while staying there.
            if (in_bus && state_nxt == BUS) begin
                if (tmo_cnt != TW'(p_TIMEOUT)) tmo_cnt <= tmo_cnt + TW'(1);
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule
